// File: rtl/fetch.sv
// RV32 instruction fetch stage: owns the PC, issues one outstanding word read to
// instruction memory, and feeds decode through output registers plus a one-entry skid buffer.
module fetch #(
  parameter logic [31:0] RESET_ADDR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        bubble,
  input  logic        kill,
  input  logic        jump,
  input  logic [31:0] target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] ir,
  output logic [31:0] pc,
  output logic        ir_valid
);

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic [31:0] r_fpc;
  logic        r_out;
  logic [31:0] r_opc;
  logic        r_drop;
  logic        r_bv;
  logic [31:0] r_bpc;
  logic [31:0] r_bir;
  logic [31:0] r_ir;
  logic [31:0] r_pc;
  logic        r_irValid;

  logic        w_hold;
  logic        w_grant;
  logic        w_resp;
  logic        w_live;
  logic [31:0] w_target;

  assign w_hold   = r_irValid & bubble & ~jump & ~kill;
  // A new request may issue in the same cycle the previous one returns, unless decode is holding.
  assign imem_req = ~reset & ~jump & ~r_bv & (~r_out | (imem_rvalid & ~w_hold));
  assign w_grant  = imem_req & imem_gnt;
  assign w_resp   = imem_rvalid & r_out;
  assign w_live   = w_resp & ~r_drop;
  assign w_target = target & 32'hFFFF_FFFC;

  assign imem_addr = r_fpc;
  assign ir        = r_ir;
  assign pc        = r_pc;
  assign ir_valid  = r_irValid;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_fpc     <= RESET_ADDR;
      r_out     <= 1'b0;
      r_opc     <= 32'h0;
      r_drop    <= 1'b0;
      r_bv      <= 1'b0;
      r_bpc     <= 32'h0;
      r_bir     <= 32'h0;
      r_ir      <= NOP;
      r_pc      <= RESET_ADDR;
      r_irValid <= 1'b0;
    end else begin
      if (w_grant) begin
        r_opc <= r_fpc;
        r_fpc <= r_fpc + 32'd4;
        r_out <= 1'b1;
      end else if (w_resp) begin
        r_out <= 1'b0;
      end

      if (w_resp && r_drop) begin
        r_drop <= 1'b0;
      end

      // Squashing marks an in-flight response stale; one arriving right now is simply not loaded.
      if (jump) begin
        r_fpc     <= w_target;
        r_irValid <= 1'b0;
        r_bv      <= 1'b0;
        r_drop    <= r_out & ~imem_rvalid;
      end else if (kill) begin
        r_irValid <= 1'b0;
        r_bv      <= 1'b0;
        r_drop    <= r_out & ~imem_rvalid;
      end else if (w_hold) begin
        if (w_live) begin
          r_bir <= imem_rdata;
          r_bpc <= r_opc;
          r_bv  <= 1'b1;
        end
      end else if (r_bv) begin
        r_ir      <= r_bir;
        r_pc      <= r_bpc;
        r_irValid <= 1'b1;
        r_bv      <= 1'b0;
      end else if (w_live) begin
        r_ir      <= imem_rdata;
        r_pc      <= r_opc;
        r_irValid <= 1'b1;
      end else begin
        r_irValid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fetch.sv
// Directed bench for fetch: table-driven pipeline trace through a latency-programmable
// memory model, plus hand sequences for mid-run reset and a wrapping reset address.
module tb_fetch;

  logic        clk = 1'b0;
  logic        reset;
  logic        bubble, kill, jump;
  logic [31:0] target;
  logic        imem_req, imem_gnt, imem_rvalid;
  logic [31:0] imem_addr, imem_rdata;
  logic [31:0] ir, pc;
  logic        ir_valid;

  logic        reset2;
  logic        zero2 = 1'b0;
  logic [31:0] zeroTgt2 = 32'h0;
  logic        req2, rv2;
  logic [31:0] addr2, ir2, pc2;
  logic        valid2;
  logic [31:0] rdata2 = 32'h0;

  int nCompared = 0;
  int nMismatched = 0;

  int          memLat = 1;
  logic        gntEn = 1'b1;
  int          memCnt = 0;
  logic [31:0] memAddr = 32'h0;

  typedef struct {
    logic        bub;
    logic        kil;
    logic        jmp;
    logic [31:0] tgt;
    int          lat;
    logic        expReq;
    logic [31:0] expAddr;
    logic        expValid;
    logic [31:0] expPc;
  } vec_t;

  vec_t vecs[$];

  always #5 clk = ~clk;

  fetch u_dut (
    .clk(clk), .reset(reset), .bubble(bubble), .kill(kill), .jump(jump), .target(target),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .ir(ir), .pc(pc), .ir_valid(ir_valid)
  );

  fetch #(.RESET_ADDR(32'hFFFF_FFF8)) u_dut2 (
    .clk(clk), .reset(reset2), .bubble(zero2), .kill(zero2), .jump(zero2), .target(zeroTgt2),
    .imem_req(req2), .imem_addr(addr2), .imem_gnt(1'b1),
    .imem_rvalid(rv2), .imem_rdata(rdata2),
    .ir(ir2), .pc(pc2), .ir_valid(valid2)
  );

  function automatic logic [31:0] insnAt(input logic [31:0] a);
    return a ^ 32'h5A00_0013;
  endfunction

  // Memory model: responds memLat cycles after grant; it is deliberately not reset with the DUT.
  assign imem_gnt    = gntEn;
  assign imem_rvalid = (memCnt == 1);
  assign imem_rdata  = insnAt(memAddr);

  always @(posedge clk) begin
    if (imem_req && imem_gnt) begin
      memCnt  <= memLat;
      memAddr <= imem_addr;
    end else if (memCnt != 0) begin
      memCnt <= memCnt - 1;
    end
    rv2 <= req2;
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    nCompared++;
    if (actual !== expected) begin
      nMismatched++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    bubble = v.bub;
    kill   = v.kil;
    jump   = v.jmp;
    target = v.tgt;
    memLat = v.lat;
  endtask

  task automatic addVec(input logic b, input logic k, input logic j, input logic [31:0] t, input int l,
                        input logic er, input logic [31:0] ea, input logic ev, input logic [31:0] ep);
    vec_t v;
    v.bub = b; v.kil = k; v.jmp = j; v.tgt = t; v.lat = l;
    v.expReq = er; v.expAddr = ea; v.expValid = ev; v.expPc = ep;
    vecs.push_back(v);
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; reset2 = 1'b1;
    bubble = 1'b0; kill = 1'b0; jump = 1'b0; target = 32'h0;

    //      bub kil jmp target   lat req addr       vld pc
    addVec(0, 0, 0, 32'h0,   1, 1, 32'h000, 0, 32'h000);
    addVec(0, 0, 0, 32'h0,   1, 1, 32'h004, 0, 32'h000);
    addVec(0, 0, 0, 32'h0,   1, 1, 32'h008, 1, 32'h000);
    addVec(1, 0, 0, 32'h0,   1, 0, 32'h00C, 1, 32'h004);
    addVec(1, 0, 0, 32'h0,   1, 0, 32'h00C, 1, 32'h004);
    addVec(1, 0, 0, 32'h0,   1, 0, 32'h00C, 1, 32'h004);
    addVec(0, 0, 0, 32'h0,   1, 0, 32'h00C, 1, 32'h004);
    addVec(0, 0, 0, 32'h0,   1, 1, 32'h00C, 1, 32'h008);
    addVec(0, 0, 0, 32'h0,   3, 1, 32'h010, 0, 32'h008);
    addVec(0, 0, 1, 32'h103, 1, 0, 32'h014, 1, 32'h00C);
    addVec(0, 0, 0, 32'h0,   1, 0, 32'h100, 0, 32'h00C);
    addVec(0, 0, 0, 32'h0,   1, 1, 32'h100, 0, 32'h00C);
    addVec(0, 0, 0, 32'h0,   1, 1, 32'h104, 0, 32'h00C);
    addVec(1, 0, 0, 32'h0,   1, 0, 32'h108, 1, 32'h100);
    addVec(0, 1, 0, 32'h0,   1, 0, 32'h108, 1, 32'h100);
    addVec(0, 0, 0, 32'h0,   1, 1, 32'h108, 0, 32'h100);
    addVec(1, 0, 0, 32'h0,   1, 1, 32'h10C, 0, 32'h100);
    addVec(0, 0, 0, 32'h0,   1, 1, 32'h110, 1, 32'h108);

    nextCycle();
    nextCycle();
    @(negedge clk);
    checkOutput("rst_req", {31'h0, imem_req}, 32'h0);
    checkOutput("rst_valid", {31'h0, ir_valid}, 32'h0);
    checkOutput("rst_pc", pc, 32'h0);
    checkOutput("rst_ir", ir, 32'h0000_0013);
    checkOutput("rst_addr", imem_addr, 32'h0);
    nextCycle();
    reset = 1'b0;

    foreach (vecs[i]) begin
      applyStimulus(vecs[i]);
      @(negedge clk);
      checkOutput($sformatf("v%0d_req", i), {31'h0, imem_req}, {31'h0, vecs[i].expReq});
      checkOutput($sformatf("v%0d_addr", i), imem_addr, vecs[i].expAddr);
      checkOutput($sformatf("v%0d_valid", i), {31'h0, ir_valid}, {31'h0, vecs[i].expValid});
      checkOutput($sformatf("v%0d_pc", i), pc, vecs[i].expPc);
      if (vecs[i].expValid)
        checkOutput($sformatf("v%0d_ir", i), ir, insnAt(vecs[i].expPc));
      nextCycle();
    end

    // Mid-run reset with a 3-cycle request in flight; its response lands after release.
    bubble = 1'b0; kill = 1'b0; jump = 1'b0; memLat = 3;
    @(negedge clk);
    checkOutput("mr_req_before", {31'h0, imem_req}, 32'h1);
    checkOutput("mr_pc_before", pc, 32'h10C);
    nextCycle();
    reset = 1'b1;
    memLat = 1;
    @(negedge clk);
    checkOutput("mr_req", {31'h0, imem_req}, 32'h0);
    checkOutput("mr_valid", {31'h0, ir_valid}, 32'h0);
    checkOutput("mr_pc", pc, 32'h0);
    checkOutput("mr_ir", ir, 32'h0000_0013);
    checkOutput("mr_addr", imem_addr, 32'h0);
    nextCycle();
    nextCycle();
    reset = 1'b0;
    gntEn = 1'b0;
    @(negedge clk);
    checkOutput("mr_stale_rvalid", {31'h0, imem_rvalid}, 32'h1);
    checkOutput("mr_req_after", {31'h0, imem_req}, 32'h1);
    checkOutput("mr_addr_after", imem_addr, 32'h0);
    nextCycle();
    gntEn = 1'b1;
    @(negedge clk);
    checkOutput("mr_stale_ignored", {31'h0, ir_valid}, 32'h0);
    checkOutput("mr_restart_addr", imem_addr, 32'h0);
    nextCycle();
    @(negedge clk);
    checkOutput("mr_next_addr", imem_addr, 32'h4);
    nextCycle();
    @(negedge clk);
    checkOutput("mr_first_valid", {31'h0, ir_valid}, 32'h1);
    checkOutput("mr_first_pc", pc, 32'h0);
    checkOutput("mr_first_ir", ir, insnAt(32'h0));
    nextCycle();

    // Reset address near the top of the space: fetch PC must wrap to zero.
    reset2 = 1'b0;
    @(negedge clk);
    checkOutput("wrap_req0", {31'h0, req2}, 32'h1);
    checkOutput("wrap_addr0", addr2, 32'hFFFF_FFF8);
    nextCycle();
    @(negedge clk);
    checkOutput("wrap_addr1", addr2, 32'hFFFF_FFFC);
    nextCycle();
    @(negedge clk);
    checkOutput("wrap_addr2", addr2, 32'h0000_0000);
    checkOutput("wrap_pc2", pc2, 32'hFFFF_FFF8);
    checkOutput("wrap_valid2", {31'h0, valid2}, 32'h1);
    nextCycle();
    @(negedge clk);
    checkOutput("wrap_addr3", addr2, 32'h0000_0004);
    checkOutput("wrap_pc3", pc2, 32'hFFFF_FFFC);
    nextCycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
